// File: rtl/universal_shift_register_if.sv
// Bus bundle for universal_shift_register: the control/data inputs and the observed outputs.
interface universal_shift_register_if #(
   parameter int unsigned WIDTH = 16
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic             en_i;
   logic [2:0]       mode_i;
   logic [WIDTH-1:0] load_data_i;
   logic             ser_in_i;
   logic [WIDTH-1:0] out_o;
   logic             ser_out_o;
   logic [CW-1:0]    count_o;
   logic             done_o;

   modport master (
      output en_i, mode_i, load_data_i, ser_in_i,
      input  out_o, ser_out_o, count_o, done_o
   );

   modport slave (
      input  en_i, mode_i, load_data_i, ser_in_i,
      output out_o, ser_out_o, count_o, done_o
   );
endinterface

// File: rtl/universal_shift_register.sv
// Universal shift register: shift/rotate in either direction, parallel load and clear,
// with a saturating count of shift operations since the last load/clear/reset.
module universal_shift_register #(
   parameter int unsigned       WIDTH       = 16,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input logic                       clk,
   input logic                       reset,
   universal_shift_register_if.slave usr_bus
);
   localparam int unsigned   CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);

   typedef enum logic [2:0] {
      ModeHold  = 3'b000,
      ModeShl   = 3'b001,
      ModeShr   = 3'b010,
      ModeRol   = 3'b011,
      ModeRor   = 3'b100,
      ModeLoad  = 3'b101,
      ModeClear = 3'b110
   } mode_e;

   logic [WIDTH-1:0] r_data, w_data_nxt;
   logic [CW-1:0]    r_count, w_count_nxt;
   logic             r_dir_left, w_dir_left_nxt;
   logic             w_shift_op;

   // Next-state decode of the selected operation; reserved mode 111 falls into default (hold).
   always_comb begin
      w_data_nxt     = r_data;
      w_count_nxt    = r_count;
      w_dir_left_nxt = r_dir_left;
      w_shift_op     = 1'b0;
      if (usr_bus.en_i) begin
         case (usr_bus.mode_i)
            ModeShl: begin
               w_data_nxt     = {r_data[WIDTH-2:0], usr_bus.ser_in_i};
               w_dir_left_nxt = 1'b1;
               w_shift_op     = 1'b1;
            end
            ModeShr: begin
               w_data_nxt     = {usr_bus.ser_in_i, r_data[WIDTH-1:1]};
               w_dir_left_nxt = 1'b0;
               w_shift_op     = 1'b1;
            end
            ModeRol: begin
               w_data_nxt     = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
               w_dir_left_nxt = 1'b1;
               w_shift_op     = 1'b1;
            end
            ModeRor: begin
               w_data_nxt     = {r_data[0], r_data[WIDTH-1:1]};
               w_dir_left_nxt = 1'b0;
               w_shift_op     = 1'b1;
            end
            ModeLoad: begin
               w_data_nxt  = usr_bus.load_data_i;
               w_count_nxt = '0;
            end
            ModeClear: begin
               w_data_nxt  = RESET_VALUE;
               w_count_nxt = '0;
            end
            default: ;
         endcase
         // Count saturates at WIDTH: it marks "a full word has passed", not a position.
         if (w_shift_op && (r_count != COUNT_MAX)) begin
            w_count_nxt = r_count + 1'b1;
         end
      end
   end

   // State registers with synchronous reset overriding any operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data     <= RESET_VALUE;
         r_count    <= '0;
         r_dir_left <= 1'b1;
      end else begin
         r_data     <= w_data_nxt;
         r_count    <= w_count_nxt;
         r_dir_left <= w_dir_left_nxt;
      end
   end

   assign usr_bus.out_o     = r_data;
   assign usr_bus.count_o   = r_count;
   assign usr_bus.done_o    = (r_count == COUNT_MAX);
   // The bit the next shift in the current direction would push out.
   assign usr_bus.ser_out_o = r_dir_left ? r_data[WIDTH-1] : r_data[0];
endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: four instances (16/RV=0, 16/RV=0x00FF, 2, 33) share
// stimulus; every cycle all are compared with an arithmetic reference model, and the
// first instance is also checked against a hand-derived vector table.
module tb_universal_shift_register;
   localparam int NDUT = 4;
   localparam logic [2:0] M_HOLD = 3'd0, M_SHL = 3'd1, M_SHR = 3'd2, M_ROL = 3'd3,
                          M_ROR = 3'd4, M_LOAD = 3'd5, M_CLR = 3'd6, M_RSV = 3'd7;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        sin = 1'b0;
   logic [2:0]  mode = 3'd0;
   logic [32:0] ld = '0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   universal_shift_register_if #(.WIDTH(16)) if_a ();
   universal_shift_register_if #(.WIDTH(16)) if_b ();
   universal_shift_register_if #(.WIDTH(2))  if_c ();
   universal_shift_register_if #(.WIDTH(33)) if_d ();

   assign if_a.en_i = en;  assign if_a.mode_i = mode;  assign if_a.ser_in_i = sin;
   assign if_b.en_i = en;  assign if_b.mode_i = mode;  assign if_b.ser_in_i = sin;
   assign if_c.en_i = en;  assign if_c.mode_i = mode;  assign if_c.ser_in_i = sin;
   assign if_d.en_i = en;  assign if_d.mode_i = mode;  assign if_d.ser_in_i = sin;
   assign if_a.load_data_i = ld[15:0];
   assign if_b.load_data_i = ld[15:0];
   assign if_c.load_data_i = ld[1:0];
   assign if_d.load_data_i = ld;

   universal_shift_register #(.WIDTH(16), .RESET_VALUE(16'h0000)) u_a (
      .clk(clk), .reset(reset), .usr_bus(if_a.slave));
   universal_shift_register #(.WIDTH(16), .RESET_VALUE(16'h00FF)) u_b (
      .clk(clk), .reset(reset), .usr_bus(if_b.slave));
   universal_shift_register #(.WIDTH(2), .RESET_VALUE(2'b10)) u_c (
      .clk(clk), .reset(reset), .usr_bus(if_c.slave));
   universal_shift_register #(.WIDTH(33), .RESET_VALUE(33'h1_2345_6789)) u_d (
      .clk(clk), .reset(reset), .usr_bus(if_d.slave));

   logic [63:0] act_out [NDUT];
   logic [63:0] act_cnt [NDUT];
   logic [63:0] act_done[NDUT];
   logic [63:0] act_so  [NDUT];

   always_comb begin
      act_out[0] = 64'(if_a.out_o); act_cnt[0] = 64'(if_a.count_o);
      act_done[0] = 64'(if_a.done_o); act_so[0] = 64'(if_a.ser_out_o);
      act_out[1] = 64'(if_b.out_o); act_cnt[1] = 64'(if_b.count_o);
      act_done[1] = 64'(if_b.done_o); act_so[1] = 64'(if_b.ser_out_o);
      act_out[2] = 64'(if_c.out_o); act_cnt[2] = 64'(if_c.count_o);
      act_done[2] = 64'(if_c.done_o); act_so[2] = 64'(if_c.ser_out_o);
      act_out[3] = 64'(if_d.out_o); act_cnt[3] = 64'(if_d.count_o);
      act_done[3] = 64'(if_d.done_o); act_so[3] = 64'(if_d.ser_out_o);
   end

   // Reference model state, one slot per instance
   int unsigned m_w [NDUT] = '{16, 16, 2, 33};
   logic [63:0] m_rv[NDUT] = '{64'h0, 64'h00FF, 64'h2, 64'h1_2345_6789};
   logic [63:0] m_out[NDUT];
   int          m_cnt[NDUT];
   bit          m_left[NDUT];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < NDUT; i++) begin
         logic [63:0] mask;
         logic [63:0] o;
         int unsigned w;
         bit          shifted;
         w       = m_w[i];
         mask    = (64'd1 << w) - 64'd1;
         o       = m_out[i];
         shifted = 1'b0;
         if (reset) begin
            m_out[i] = m_rv[i]; m_cnt[i] = 0; m_left[i] = 1'b1;
         end else if (en) begin
            case (mode)
               M_SHL: begin
                  m_out[i] = ((o << 1) | 64'(sin)) & mask; m_left[i] = 1'b1; shifted = 1'b1;
               end
               M_SHR: begin
                  m_out[i] = (o >> 1) | (64'(sin) << (w - 1)); m_left[i] = 1'b0; shifted = 1'b1;
               end
               M_ROL: begin
                  m_out[i] = ((o << 1) | (o >> (w - 1))) & mask; m_left[i] = 1'b1; shifted = 1'b1;
               end
               M_ROR: begin
                  m_out[i] = (o >> 1) | ((o & 64'd1) << (w - 1)); m_left[i] = 1'b0; shifted = 1'b1;
               end
               M_LOAD: begin m_out[i] = 64'(ld) & mask; m_cnt[i] = 0; end
               M_CLR:  begin m_out[i] = m_rv[i];        m_cnt[i] = 0; end
               default: ;
            endcase
            if (shifted && (m_cnt[i] < int'(w))) m_cnt[i]++;
         end
      end
   endtask

   task automatic check_model();
      for (int i = 0; i < NDUT; i++) begin
         logic [63:0] so;
         so = m_left[i] ? ((m_out[i] >> (m_w[i] - 1)) & 64'd1) : (m_out[i] & 64'd1);
         chk($sformatf("model.w%0d.out", m_w[i]),  act_out[i],  m_out[i]);
         chk($sformatf("model.w%0d.cnt", m_w[i]),  act_cnt[i],  64'(m_cnt[i]));
         chk($sformatf("model.w%0d.done", m_w[i]), act_done[i], 64'(m_cnt[i] == int'(m_w[i])));
         chk($sformatf("model.w%0d.ser", m_w[i]),  act_so[i],   so);
      end
   endtask

   // One clock: DUT and model both take the edge, outputs are compared 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   typedef struct {
      bit          en;
      logic [2:0]  mode;
      logic [15:0] ld;
      bit          sin;
      logic [15:0] eout;
      int          ecnt;
      bit          edone;
      bit          eso;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit e, input logic [2:0] m, input logic [15:0] d,
                               input bit s, input logic [15:0] eo, input int ec,
                               input bit ed, input bit es);
      vec_t v;
      v.en = e; v.mode = m; v.ld = d; v.sin = s;
      v.eout = eo; v.ecnt = ec; v.edone = ed; v.eso = es;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [15:0] fill_exp[16];
      logic [15:0] drain_exp[16];
      bit          drain_so[16];
      bit          pat[4];
      int          r;

      pat       = '{1'b1, 1'b0, 1'b1, 1'b1};
      fill_exp  = '{16'h0001, 16'h0002, 16'h0005, 16'h000B, 16'h0017, 16'h002E, 16'h005D,
                    16'h00BB, 16'h0177, 16'h02EE, 16'h05DD, 16'h0BBB, 16'h1777, 16'h2EEE,
                    16'h5DDD, 16'hBBBB};
      drain_exp = '{16'h52E1, 16'h2970, 16'h14B8, 16'h0A5C, 16'h052E, 16'h0297, 16'h014B,
                    16'h00A5, 16'h0052, 16'h0029, 16'h0014, 16'h000A, 16'h0005, 16'h0002,
                    16'h0001, 16'h0000};
      drain_so  = '{1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0};

      // SIPO fill, saturation, LOAD while done
      for (int k = 0; k < 16; k++)
         add(1, M_SHL, 16'h0, pat[k % 4], fill_exp[k], k + 1, k == 15, k == 15);
      add(1, M_SHL,  16'h0,    1, 16'h7777, 16, 1, 0);
      add(1, M_LOAD, 16'hFFFF, 0, 16'hFFFF, 0,  0, 1);
      // PISO drain
      add(1, M_LOAD, 16'hA5C3, 0, 16'hA5C3, 0,  0, 1);
      for (int k = 0; k < 16; k++)
         add(1, M_SHR, 16'h0, 0, drain_exp[k], k + 1, k == 15, drain_so[k]);
      // Rotate (LOAD arrives while done is high)
      add(1, M_LOAD, 16'h8001, 0, 16'h8001, 0, 0, 1);
      add(1, M_ROL,  16'h0,    0, 16'h0003, 1, 0, 0);
      add(1, M_ROR,  16'h0,    0, 16'h8001, 2, 0, 1);
      add(1, M_ROR,  16'h0,    0, 16'hC000, 3, 0, 0);
      // Hold behaviour and clear
      add(1, M_LOAD, 16'h1234, 0, 16'h1234, 0, 0, 0);
      add(1, M_RSV,  16'hFFFF, 1, 16'h1234, 0, 0, 0);
      add(0, M_SHL,  16'hFFFF, 1, 16'h1234, 0, 0, 0);
      add(0, M_LOAD, 16'hFFFF, 1, 16'h1234, 0, 0, 0);
      add(0, M_CLR,  16'hFFFF, 1, 16'h1234, 0, 0, 0);
      add(1, M_CLR,  16'hFFFF, 1, 16'h0000, 0, 0, 0);

      // Reset held two cycles with random en/mode
      for (int k = 0; k < 2; k++) begin
         reset = 1'b1; en = 1'($urandom); mode = 3'($urandom); sin = 1'($urandom);
         ld = 33'({$urandom, $urandom});
         step();
         chk("rst.out", act_out[0], 64'h0);
         chk("rst.cnt", act_cnt[0], 64'h0);
         chk("rst.done", act_done[0], 64'h0);
         chk("rst.ser", act_so[0], 64'h0);
      end
      reset = 1'b0;
      // Disabled: state must hold
      for (int k = 0; k < 5; k++) begin
         en = 1'b0; mode = 3'($urandom); sin = 1'($urandom); ld = 33'({$urandom, $urandom});
         step();
         chk("idle.out", act_out[0], 64'h0);
         chk("idle.cnt", act_cnt[0], 64'h0);
      end

      foreach (tbl[k]) begin
         en = tbl[k].en; mode = tbl[k].mode; ld = 33'(tbl[k].ld); sin = tbl[k].sin;
         step();
         chk($sformatf("tbl%0d.out", k),  act_out[0],  64'(tbl[k].eout));
         chk($sformatf("tbl%0d.cnt", k),  act_cnt[0],  64'(tbl[k].ecnt));
         chk($sformatf("tbl%0d.done", k), act_done[0], 64'(tbl[k].edone));
         chk($sformatf("tbl%0d.ser", k),  act_so[0],   64'(tbl[k].eso));
      end
      chk("clear.rv00ff", act_out[1], 64'h00FF);
      chk("clear.cnt", act_cnt[1], 64'h0);

      // Reset landing on the 8th SHL of a fill
      en = 1'b1; mode = M_SHL; sin = 1'b1;
      repeat (7) step();
      reset = 1'b1;
      step();
      chk("midrst.out", act_out[0], 64'h0);
      chk("midrst.cnt", act_cnt[0], 64'h0);
      chk("midrst.out33", act_out[3], 64'h1_2345_6789);
      reset = 1'b0;

      // Long fill to saturate the 33-bit instance
      for (int k = 0; k < 40; k++) begin
         en = 1'b1; mode = M_SHL; sin = 1'($urandom);
         step();
      end

      // Randomised traffic, shift-heavy so counters reach saturation
      for (int k = 0; k < 3000; k++) begin
         reset = ($urandom_range(63) == 0);
         en    = ($urandom_range(7) != 0);
         r     = int'($urandom_range(31));
         mode  = (r < 28) ? 3'(1 + (r % 4)) : 3'($urandom_range(7));
         sin   = 1'($urandom);
         ld    = 33'({$urandom, $urandom});
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
